// File: rtl/hex_arb_pkg.sv
`default_nettype none
// ============================================================================
// hex_arb_pkg: shared types and constants for the HEX display arbiter
// Revision: 1.0
// ============================================================================
package hex_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        RC   = 2'd2
    } arb_state_t;

    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/hex7seg_decoder.sv
`default_nettype none
// ============================================================================
// hex7seg_decoder: 4-bit hex value to active-low 7-segment pattern (bit0=a)
// Revision: 1.0
// ============================================================================
module hex7seg_decoder
    import hex_arb_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hex_display_arbiter.sv
`default_nettype none
// ============================================================================
// hex_display_arbiter: round-robin sharing of HEX digits between Nios (Avalon)
// and ReCOP (valid/ready), with minimum grant hold. Option: HEX_ARB_RC_PREEMPT_EN
// Revision: 1.0
// ============================================================================
module hex_display_arbiter
    import hex_arb_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    input  logic                    rc_valid,
    input  logic [4*NUM_DIGITS-1:0] rc_value,
    output logic                    rc_ready,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int                 c_cnt_w     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);

    arb_state_t              r_state;
    arb_state_t              r_last_owner;
    logic [c_cnt_w-1:0]      r_hold_cnt;
    logic [4*NUM_DIGITS-1:0] r_cpu_value;
    logic [4*NUM_DIGITS-1:0] r_rc_reg;
    logic                    r_cpu_req;
    logic                    r_blank;
`ifdef HEX_ARB_RC_PREEMPT_EN
    logic                    r_rc_valid_d;
`endif

    logic                    w_write;
    logic                    w_hold_done;
    logic                    w_show;
    logic [7*NUM_DIGITS-1:0] w_seg;
    logic                    w_unused;

    assign w_write     = chipselect && !write_n;
    assign w_hold_done = (r_hold_cnt == '0);
    assign w_unused    = ^writedata;
    assign rc_ready    = (r_state == RC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_value <= '0;
            r_cpu_req   <= 1'b0;
            r_blank     <= 1'b0;
        end else if (w_write) begin
            if (address == ADDR_VALUE) begin
                r_cpu_value <= writedata[4*NUM_DIGITS-1:0];
            end else if (address == ADDR_CTRL) begin
                r_cpu_req <= writedata[0];
                r_blank   <= writedata[1];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_VALUE:  readdata[4*NUM_DIGITS-1:0] = r_cpu_value;
            ADDR_CTRL:   readdata[1:0] = {r_blank, r_cpu_req};
            ADDR_STATUS: readdata[2:0] = {rc_valid, r_state};
            default:     readdata = '0;
        endcase
    end

    // Every grant (including a direct owner switch) reloads the hold counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_owner <= RC;
            r_hold_cnt   <= '0;
`ifdef HEX_ARB_RC_PREEMPT_EN
            r_rc_valid_d <= 1'b0;
`endif
        end else begin
`ifdef HEX_ARB_RC_PREEMPT_EN
            r_rc_valid_d <= rc_valid;
`endif
            if (r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (r_cpu_req && (!rc_valid || r_last_owner == RC)) begin
                        r_state      <= CPU;
                        r_last_owner <= CPU;
                        r_hold_cnt   <= c_hold_load;
                    end else if (rc_valid) begin
                        r_state      <= RC;
                        r_last_owner <= RC;
                        r_hold_cnt   <= c_hold_load;
                    end
                end
                CPU: begin
`ifdef HEX_ARB_RC_PREEMPT_EN
                    if (rc_valid && !r_rc_valid_d) begin
                        r_state      <= RC;
                        r_last_owner <= RC;
                        r_hold_cnt   <= c_hold_load;
                    end else
`endif
                    if (w_hold_done) begin
                        if (rc_valid) begin
                            r_state      <= RC;
                            r_last_owner <= RC;
                            r_hold_cnt   <= c_hold_load;
                        end else if (!r_cpu_req) begin
                            r_state <= IDLE;
                        end
                    end
                end
                RC: begin
                    if (w_hold_done) begin
                        if (r_cpu_req) begin
                            r_state      <= CPU;
                            r_last_owner <= CPU;
                            r_hold_cnt   <= c_hold_load;
                        end else if (!rc_valid) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rc_reg <= '0;
        end else if (rc_valid && rc_ready) begin
            r_rc_reg <= rc_value;
        end
    end

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            logic [3:0] w_nibble;
            assign w_nibble = (r_state == RC) ? r_rc_reg[4*i +: 4] : r_cpu_value[4*i +: 4];
            hex7seg_decoder u_dec (
                .digit (w_nibble),
                .seg   (w_seg[7*i +: 7])
            );
        end
    endgenerate

    assign w_show = !r_blank && (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_out <= '1;
        end else begin
            hex_out <= w_show ? w_seg : {NUM_DIGITS{SEG_BLANK}};
        end
    end

endmodule
`default_nettype wire

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Shares the board's 7-segment HEX digits between two requesters: the Nios II CPU, through an Avalon-MM slave, and the ReCOP core, through a valid/ready stream. A three-state grant FSM does round-robin arbitration. Each grant has a minimum hold time so neither side can flicker the display, and the block drives registered, active-low segment outputs. It sits in the Nios/ReCOP system alongside the HEX PIOs and replaces direct PIO ownership of the digits.

## Interface
- NUM_DIGITS, 4: number of HEX digits driven; range 1..8.
- HOLD_CYCLES, 50000000: minimum grant duration in clk cycles; must be ≥1.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data; combinational, zero wait states
- rc_valid  in  1  ReCOP has a display value and requests the display
- rc_value  in  4*NUM_DIGITS  ReCOP hex value; digit i is bits [4i+3:4i]
- rc_ready  out  1  high while ReCOP owns the display
- hex_out  out  7*NUM_DIGITS  segments, active-low; digit i is bits [7i+6:7i], with bit0 = a and bit6 = g

## Operation
- Registers:
  - address 0, CPU_VALUE: bits [4*NUM_DIGITS-1:0], read/write.
  - address 1, CONTROL: bit0 cpu_req, bit1 blank; read/write.
  - address 2, STATUS: bits[1:0] owner (0 = IDLE, 1 = CPU, 2 = RC), bit2 rc_valid; read-only.
  - address 3 reads 0.
  - Unused bits read 0. Writes to addresses 2 and 3 are ignored.
- A write occurs on chipselect && !write_n and updates the register at the next clk edge.
- FSM states are IDLE, CPU and RC. The CPU requests with the registered cpu_req; ReCOP requests with rc_valid.
- IDLE:
  - If only one side requests, grant it.
  - If both request, grant the side that is not last_owner. last_owner resets to RC, so the CPU wins the first tie.
- Entering CPU or RC:
  - load hold_cnt with HOLD_CYCLES-1;
  - decrement each cycle, saturating at 0;
  - hold_done = (hold_cnt == 0);
  - last_owner is updated to the new owner.
- In CPU or RC, once hold_done is true:
  - if the other side requests, switch directly to it (reload hold_cnt);
  - else if the owner's own request is low, go to IDLE;
  - else stay.
- Before hold_done, the owner keeps the grant even if its request drops.
- rc_ready = (state == RC). Each cycle with rc_valid && rc_ready latches rc_value into rc_reg.
- Display source:
  - IDLE: every digit 7'h7F (blank).
  - CPU: decode CPU_VALUE.
  - RC: decode rc_reg.
  - CONTROL.blank = 1 forces all digits blank in every state.
- Decode: 0 → 7'h40, 1 → 7'h79, 8 → 7'h00, F → 7'h0E; the full standard hex font applies.
- A write to CPU_VALUE while the CPU is not the owner is stored and shown when the CPU is next granted.

## Timing
- Reset values:
  - state IDLE, last_owner RC, hold_cnt 0;
  - CPU_VALUE 0, CONTROL 0, rc_reg 0;
  - rc_ready 0, hex_out all ones, readdata per the zeroed registers.
- Reset asserted mid-grant returns the block to IDLE asynchronously and blanks the display immediately.
- Latencies, counted from the write cycle N:
  - cpu_req written in cycle N → register set at edge N+1 → state CPU at edge N+2 → hex_out updated at edge N+3.
  - rc_valid high in cycle M while IDLE → state RC at edge M+1 → rc_reg latched at edge M+2 → hex_out updated at edge M+3.
- hex_out is always registered: one cycle after the state, rc_reg, CPU_VALUE or blank change.
- With HOLD_CYCLES = 1, hold_done is true in the first owned cycle.

## Configuration
- HEX_ARB_RC_PREEMPT_EN defined: when the CPU owns the display and rc_valid rises, the FSM switches to RC at the next edge regardless of hold_done. A CPU request while RC owns the display still waits for hold_done.
- Not defined: both sides are symmetric and switching happens only when hold_done is true.

## Structure
- Package hex_arb_pkg holds:
  - the state enum (IDLE/CPU/RC, 2 bits);
  - register address constants ADDR_VALUE, ADDR_CTRL, ADDR_STATUS;
  - SEG_BLANK = 7'h7F.
- Sub-module hex7seg_decoder: combinational 4-bit → 7-bit active-low decode, instantiated once per digit with a generate loop.

## Test plan
Bench parameters: NUM_DIGITS = 4, HOLD_CYCLES = 8.

- Reset: release reset → hex_out = 28'hFFFFFFF, STATUS = 0, rc_ready = 0.
- CPU display: write CPU_VALUE = 16'h10F8, then CONTROL = 1 → STATUS owner = 1; hex_out digits 3..0 = 7'h79, 7'h40, 7'h0E, 7'h00, appearing 3 cycles after the CONTROL write.
- Tie: cpu_req and rc_valid rise together, rc_value = 16'h8888 → CPU is granted first. After 8 cycles the owner becomes RC, every digit reads 7'h00, and rc_ready = 1.
- Hold time: RC owns the display and rc_valid drops at owned cycle 2 → RC is kept until hold_done, then IDLE and hex_out blank. With the macro on, rc_valid rising during a CPU grant switches to RC in 1 cycle.
- Blank and mid-operation reset:
  - CONTROL = 3 → hex_out all ones while STATUS owner = 1.
  - Asserting reset during an RC grant → immediate IDLE, blank display, CPU_VALUE reads 0.
